serial_receiver: RTL and testbench
==================================

# serial_receiver

Serial-to-parallel receive stage that consumes the single-wire character stream produced by the transmitter and reassembles it into bytes. It oversamples the line on a sample-tick enable and centres each bit with a mid-bit sampling point. It delivers each validated character on an 8-bit bus with a one-cycle strobe. It sits directly downstream of the transmitter's serial output and upstream of whatever consumer latches received characters.

## Interface
- DATA_BITS, 8, data bits per character (LSB first)
- OVERSAMPLE, 16, sample ticks per bit period; power of two, ≥4
- clk  in  1  sole clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- data_in  in  1  serial line; idle high; asynchronous to clk
- sample_en  in  1  oversample tick, one clk wide, OVERSAMPLE per bit
- receive_enable  in  1  receiver armed when high
- data_out  out  DATA_BITS  last good character; held until next good one
- character_received  out  1  one-clk strobe, data_out valid
- framing_error  out  1  one-clk strobe, stop bit sampled low
- busy  out  1  high in any state other than IDLE

## Operation
- Frame: start bit (0), DATA_BITS data bits LSB first, one stop bit (1).
- data_in passes through a 2-flop synchronizer. All decisions use the synchronized value `rx_s`. A registered copy `rx_prev` updates only on sample_en.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: on sample_en with receive_enable=1, rx_prev=1 and rx_s=0 (falling edge), clear the sample counter and go to START.
- START: count sample_en ticks. At tick OVERSAMPLE/2−1:
  - rx_s=0: valid start. Clear the counter and the bit index, then go to DATA.
  - rx_s=1: glitch. Return to IDLE silently.
- DATA: at each counter value OVERSAMPLE−1, shift rx_s into the MSB of the shift register (right shift) and increment the bit index. After bit DATA_BITS−1 is captured, go to STOP.
- STOP: at counter value OVERSAMPLE−1:
  - rx_s=1: load data_out from the shift register, pulse character_received, go to IDLE.
  - rx_s=0: pulse framing_error, leave data_out unchanged, go to IDLE. No new start is detected until the line is seen high again, because of the edge rule.
- receive_enable=0 in any state: return to IDLE on the next clk. The frame in progress is discarded with no strobe and data_out unchanged.
- Counter width: clog2(OVERSAMPLE). It wraps to 0 after OVERSAMPLE−1. Bit index width: clog2(DATA_BITS)+1.

## Timing
- Reset values:
  - data_out = 0
  - character_received = 0
  - framing_error = 0
  - busy = 0
  - FSM = IDLE
  - synchronizer flops and rx_prev = 1 (line-idle)
  - counters = 0
- Line-to-decision latency: 2 clk (synchronizer), plus alignment to the next sample_en.
- Every sample point sits at the centre of a bit: the start bit at tick OVERSAMPLE/2−1, and each later bit OVERSAMPLE ticks after the previous one.
- Strobes:
  - Both strobes are registered and rise on the clk edge after the stop-bit sample_en.
  - Each lasts exactly one clk, even if sample_en is high on consecutive cycles.
  - character_received and framing_error are mutually exclusive.
- data_out changes only in the same cycle that character_received rises.
- busy rises the clk after start detection. It falls in the same cycle a strobe rises, or the cycle after an abort or glitch.
- Back-to-back frames: a start edge on the sample_en immediately after the stop sample is accepted.
- sample_en=0: state and counters hold, with no timeout.
- rst asserted mid-frame: all outputs return to reset values immediately, asynchronously.

## Structure
- Shared package `rx_pkg` contains:
  - FSM state typedef (IDLE/START/DATA/STOP)
  - OVERSAMPLE and DATA_BITS defaults
  - derived MID_SAMPLE = OVERSAMPLE/2−1 and counter-width constants
- One natural sub-module, `rx_sample_counter`:
  - Counts sample_en ticks.
  - Provides sync clear, enable, and terminal-count outputs for both the MID and FULL compares.
- The FSM, shift register and output registers live in the top module.

## Test plan
- Clean frame, OVERSAMPLE=16, byte 0xA5 sent LSB first -> data_out=0xA5, one character_received pulse, framing_error=0, busy low afterwards.
- Start glitch: line low for 4 ticks, then high -> no strobe, busy returns to 0, data_out unchanged.
- Bad stop: byte 0x3C with stop bit driven 0 -> framing_error single pulse, data_out keeps previous value; line then held low for 3 bit times and released high, then a 0x55 frame -> 0x55 received correctly.
- Back-to-back: 0x00, 0xFF, 0x81 with no idle gap -> three character_received pulses, data_out sequencing 0x00, 0xFF, 0x81.
- receive_enable dropped after bit 3 of 0x77 -> no strobe, FSM in IDLE next clk. Re-enabled, then a 0x12 frame -> 0x12 received.
- rst pulsed low during DATA of a 0x99 frame -> all outputs reset asynchronously; a subsequent 0x42 frame -> 0x42 received.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared types and default geometry for the serial receive path.
// The derived constants follow the default oversample and data-bit settings.
package rx_pkg;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int MID_SAMPLE     = OVERSAMPLE_DEF / 2 - 1;
  localparam int CNT_W          = $clog2(OVERSAMPLE_DEF);
  localparam int IDX_W          = $clog2(DATA_BITS_DEF) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/serial_receiver_if.sv
// Line-side inputs and character-side outputs of the serial receiver.
// The receiver uses the slave modport and the line driver or consumer uses the master modport.
interface serial_receiver_if #(
  parameter int DATA_BITS = rx_pkg::DATA_BITS_DEF
);

  logic                 data_in;
  logic                 sample_en;
  logic                 receive_enable;
  logic [DATA_BITS-1:0] data_out;
  logic                 character_received;
  logic                 framing_error;
  logic                 busy;

  // Handshake: character_received is a valid-only strobe with no ready or back-pressure.
  // The consumer takes data_out in the strobe cycle, or any later cycle before the next strobe,
  // because data_out holds the last good character.
  modport master (
    output data_in, sample_en, receive_enable,
    input  data_out, character_received, framing_error, busy
  );

  modport slave (
    input  data_in, sample_en, receive_enable,
    output data_out, character_received, framing_error, busy
  );

endinterface

// File: rtl/rx_sample_counter.sv
// Sample-tick counter that gives the mid-bit and full-bit compare points.
// A synchronous clear overrides counting, and the terminal counts are gated by the tick enable.
module rx_sample_counter #(
  parameter int OVERSAMPLE = rx_pkg::OVERSAMPLE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic mid_tc,
  output logic full_tc
);

  localparam int                CW   = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]     MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0]     FULL = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= (count == FULL) ? '0 : count + 1'b1;
    end
  end

  assign mid_tc  = en && (count == MID);
  assign full_tc = en && (count == FULL);

endmodule

// File: rtl/serial_receiver.sv
// Oversampled serial-to-parallel receiver: start-edge detection, mid-bit sampling and
// reassembly of each frame into data_out, with one-cycle strobes for good or bad stop bits.
module serial_receiver
  import rx_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  serial_receiver_if.slave   bus,
  output rx_state_e          dbg_state
);

  localparam int BW = $clog2(DATA_BITS) + 1;

  rx_state_e            state, state_n;
  logic                 rx_meta, rx_s, rx_prev;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] data_q;
  logic                 char_q, ferr_q;

  logic cnt_clear, mid_tc, full_tc;
  logic shift_en, idx_clear, char_n, ferr_n;

  rx_sample_counter #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .en      (bus.sample_en),
    .mid_tc  (mid_tc),
    .full_tc (full_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // A cleared enable wins over everything and discards the frame without a strobe.
  always_comb begin
    state_n   = state;
    cnt_clear = 1'b0;
    shift_en  = 1'b0;
    idx_clear = 1'b0;
    char_n    = 1'b0;
    ferr_n    = 1'b0;
    if (!bus.receive_enable) begin
      state_n   = IDLE;
      cnt_clear = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt_clear = 1'b1;
          if (bus.sample_en && rx_prev && !rx_s) state_n = START;
        end
        START: begin
          if (mid_tc) begin
            if (!rx_s) begin
              state_n   = DATA;
              cnt_clear = 1'b1;
              idx_clear = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end
        end
        DATA: begin
          if (full_tc) begin
            shift_en = 1'b1;
            if (bit_idx == BW'(DATA_BITS - 1)) state_n = STOP;
          end
        end
        STOP: begin
          if (full_tc) begin
            state_n = IDLE;
            if (rx_s) char_n = 1'b1;
            else      ferr_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Synchronizer and edge history reset to the idle-high line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= bus.data_in;
      rx_s    <= rx_meta;
      if (bus.sample_en) rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_idx <= '0;
      data_q  <= '0;
      char_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      if (idx_clear)     bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 1'b1;
      if (char_n) data_q <= shreg;
      char_q <= char_n;
      ferr_q <= ferr_n;
    end
  end

  assign bus.data_out           = data_q;
  assign bus.character_received = char_q;
  assign bus.framing_error      = ferr_q;
  assign bus.busy               = (state != IDLE);
  assign dbg_state              = state;

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver: frames are driven bit by bit on sample ticks, expected
// characters are queued when sent, and a negedge monitor compares every strobe against the queue.
module tb_serial_receiver;
  import rx_pkg::*;

  localparam int OS = 16;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  rx_state_e dbg_state;

  serial_receiver_if bus ();

  serial_receiver dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int         tick_div = 4;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] exp_q[$];
  logic [7:0] last_good = 8'h00;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Sample tick generator: one clk wide, every tick_div clocks.
  initial begin
    bus.sample_en = 1'b0;
    forever begin
      repeat (tick_div - 1) begin
        @(posedge clk);
        #1 bus.sample_en = 1'b0;
      end
      @(posedge clk);
      #1 bus.sample_en = 1'b1;
    end
  end

  // Driver tasks
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!bus.sample_en) @(posedge clk);
    end
  endtask

  task automatic send_bit(input logic b);
    #1 bus.data_in = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
  endtask

  task automatic expect_char(input logic [7:0] b);
    exp_q.push_back({1'b0, b});
    last_good = b;
  endtask

  task automatic expect_ferr();
    exp_q.push_back({1'b1, last_good});
  endtask

  task automatic idle(input int n);
    #1 bus.data_in = 1'b1;
    wait_ticks(n);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check({name, "_all_strobes_seen"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check({name, "_busy_low"}, 32'(bus.busy), 32'd0);
  endtask

  // Scoreboard monitor
  initial begin
    logic       prev_strobe;
    logic [7:0] prev_dout;
    logic [8:0] exp;
    prev_strobe = 1'b0;
    prev_dout   = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_strobe = 1'b0;
        prev_dout   = bus.data_out;
      end else begin
        if (bus.character_received || bus.framing_error) begin
          check("strobe_exclusive", 32'(bus.character_received && bus.framing_error), 32'd0);
          check("strobe_single_clk", 32'(prev_strobe), 32'd0);
          check("strobe_was_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check("strobe_kind_and_data", 32'({bus.framing_error, bus.data_out}), 32'(exp));
          end
        end
        if (bus.data_out != prev_dout)
          check("dout_changes_only_with_char", 32'(bus.character_received), 32'd1);
        prev_strobe = bus.character_received || bus.framing_error;
        prev_dout   = bus.data_out;
      end
    end
  end

  // Watchdog
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    logic [7:0] b;
    bus.data_in        = 1'b1;
    bus.receive_enable = 1'b1;
    rst                = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_data_out", 32'(bus.data_out), 32'd0);
    check("reset_char", 32'(bus.character_received), 32'd0);
    check("reset_ferr", 32'(bus.framing_error), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk);
    #1 rst = 1'b1;
    idle(20);

    // Clean frame
    expect_char(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(8);
    drain("clean_a5");
    check("clean_a5_data_out", 32'(bus.data_out), 32'hA5);

    // Start glitch: four ticks low, then high again
    #1 bus.data_in = 1'b0;
    wait_ticks(4);
    @(negedge clk);
    check("glitch_busy_seen", 32'(bus.busy), 32'd1);
    idle(24);
    drain("glitch");
    check("glitch_data_out_kept", 32'(bus.data_out), 32'hA5);

    // Bad stop bit, line stuck low for three bit times, then recovery
    expect_ferr();
    send_frame(8'h3C, 1'b0);
    wait_ticks(3 * OS);
    idle(8);
    drain("bad_stop");
    check("bad_stop_data_out_kept", 32'(bus.data_out), 32'hA5);
    expect_char(8'h55);
    send_frame(8'h55, 1'b1);
    idle(8);
    drain("after_bad_stop_55");

    // Back-to-back frames with no idle gap
    expect_char(8'h00);
    expect_char(8'hFF);
    expect_char(8'h81);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h81, 1'b1);
    idle(8);
    drain("back_to_back");

    // receive_enable dropped after bit 3 of 0x77
    b = 8'h77;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    #1 bus.receive_enable = 1'b0;
    @(posedge clk);
    #1;
    check("disable_state_idle", 32'(dbg_state), 32'(IDLE));
    check("disable_busy_low", 32'(bus.busy), 32'd0);
    bus.data_in = 1'b1;
    wait_ticks(2 * OS);
    #1 bus.receive_enable = 1'b1;
    idle(4);
    drain("disable_no_strobe");
    check("disable_data_out_kept", 32'(bus.data_out), 32'h81);
    expect_char(8'h12);
    send_frame(8'h12, 1'b1);
    idle(8);
    drain("reenable_12");

    // Asynchronous reset during the data bits of 0x99
    b = 8'h99;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(b[i]);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_data_out", 32'(bus.data_out), 32'd0);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_char", 32'(bus.character_received), 32'd0);
    check("async_rst_ferr", 32'(bus.framing_error), 32'd0);
    check("async_rst_state", 32'(dbg_state), 32'(IDLE));
    last_good      = 8'h00;
    bus.data_in    = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(20);
    expect_char(8'h42);
    send_frame(8'h42, 1'b1);
    idle(8);
    drain("after_reset_42");
    check("after_reset_data_out", 32'(bus.data_out), 32'h42);

    // sample_en high every clock
    tick_div = 1;
    idle(40);
    expect_char(8'hC3);
    send_frame(8'hC3, 1'b1);
    idle(8);
    drain("fast_tick_c3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
